// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_W data bits, optional parity, 1/2 stop bits, valid/ready output.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting at each bit centre.
module uart_rx_cfg #(
  parameter int FCLK      = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_overrun,
  output logic              rx_idle
);

  localparam int BIT_CNT  = FCLK / BAUD;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = $clog2(BIT_CNT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BREAK = 3'd5;

  localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic       PAR_ODD   = (PARITY == 2);

  if (DATA_W < 5 || DATA_W > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || BIT_CNT < 8) begin : g_cfg_err
    $error("uart_rx_cfg: illegal parameter combination");
  end

  logic              rx_meta, rx_s;
  logic [2:0]        state, state_nx;
  logic [CW-1:0]     cnt, ld_val;
  logic              ld;
  logic [3:0]        bcnt;
  logic [DATA_W-1:0] shreg;
  logic              perr, ferr_acc, ferr_now, done;
  logic              busy, sample, sample_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign busy = (state == S_START) || (state == S_DATA) ||
                (state == S_PAR)   || (state == S_STOP);

`ifdef UART_RX_MAJORITY_EN
  // Vote over cnt==1, cnt==0 and the following cycle; the counter holds at 0
  // for that extra cycle, so reloads are one shorter to keep the bit period.
  localparam int RELOAD_ADJ = 2;
  logic s_d1, s_d2, tick_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d1   <= 1'b1;
      s_d2   <= 1'b1;
      tick_d <= 1'b0;
    end else begin
      s_d1   <= rx_s;
      s_d2   <= s_d1;
      tick_d <= busy && (cnt == '0) && !tick_d;
    end
  end

  assign sample_en = tick_d;
  assign sample    = (rx_s & s_d1) | (rx_s & s_d2) | (s_d1 & s_d2);
`else
  localparam int RELOAD_ADJ = 1;

  assign sample_en = busy && (cnt == '0);
  assign sample    = rx_s;
`endif

  localparam logic [CW-1:0] HALF_LD = CW'(HALF_CNT - RELOAD_ADJ);
  localparam logic [CW-1:0] BIT_LD  = CW'(BIT_CNT - RELOAD_ADJ);

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    ld_val   = BIT_LD;
    done     = 1'b0;
    ferr_now = ferr_acc | ~sample;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          ld       = 1'b1;
          ld_val   = HALF_LD;
          state_nx = S_START;
        end
      end
      S_START: begin
        if (sample_en) begin
          if (sample) begin
            state_nx = S_IDLE;
          end else begin
            ld       = 1'b1;
            state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (sample_en) begin
          ld = 1'b1;
          if (bcnt == DATA_LAST) state_nx = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (sample_en) begin
          ld       = 1'b1;
          state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_en) begin
          if (bcnt == STOP_LAST) begin
            done     = 1'b1;
            state_nx = sample ? S_IDLE : S_BREAK;
          end else begin
            ld = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bcnt          <= '0;
      shreg         <= '0;
      perr          <= 1'b0;
      ferr_acc      <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      state <= state_nx;

      if (ld)              cnt <= ld_val;
      else if (cnt != '0)  cnt <= cnt - 1'b1;

      if (sample_en) begin
        case (state)
          S_START: begin
            bcnt     <= '0;
            perr     <= 1'b0;
            ferr_acc <= 1'b0;
          end
          S_DATA: begin
            shreg <= {sample, shreg[DATA_W-1:1]};
            bcnt  <= (bcnt == DATA_LAST) ? '0 : bcnt + 1'b1;
          end
          S_PAR:   perr <= (^shreg) ^ sample ^ PAR_ODD;
          S_STOP: begin
            ferr_acc <= ferr_now;
            bcnt     <= bcnt + 1'b1;
          end
          default: ;
        endcase
      end

      // A completed frame either replaces the held word or is dropped with an overrun pulse.
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= shreg;
          rx_parity_err <= perr;
          rx_frame_err  <= ferr_now;
          rx_valid      <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

  assign rx_idle = (state == S_IDLE);

endmodule
